// File: rtl/stream_share_rr.sv
// Round-robin sharing of one valid/ready stream unit among N requesters, with an
// in-order tag FIFO that routes each unit result back to its issuer.
// Optional burst lock (hold grant up to MAX_BURST beats): define STREAM_SHARE_LOCK_EN.
module stream_share_rr #(
  parameter int N         = 4,
  parameter int W         = 8,
  parameter int DEPTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic [N*W-1:0]             req_data,
  input  logic [N-1:0]               req_valid,
  output logic [N-1:0]               req_ready,
  output logic [W-1:0]               u_in,
  output logic                       u_in_valid,
  input  logic                       u_in_ready,
  input  logic [W-1:0]               u_out,
  input  logic                       u_out_valid,
  output logic                       u_out_ready,
  output logic [N*W-1:0]             rsp_data,
  output logic [N-1:0]               rsp_valid,
  input  logic [N-1:0]               rsp_ready,
  output logic [$clog2(DEPTH+1)-1:0] pending
);

  localparam int IW = $clog2(N);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(DEPTH+1);

  if (N < 2 || N > 8 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || MAX_BURST < 1) begin : g_bad_param
    $error("stream_share_rr: unsupported parameter set");
  end

  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] i);
    return (int'(i) == N - 1) ? '0 : i + 1'b1;
  endfunction

  logic [IW-1:0] ptr;
  logic [IW-1:0] base;
  logic [IW-1:0] cand;
  logic [IW-1:0] grant;
  logic          grant_vld;

  logic [IW-1:0] tag_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [PW-1:0] count;
  logic [IW-1:0] head;
  logic          full;
  logic          empty;
  logic          issue_ok;
  logic          push;
  logic          pop;

`ifdef STREAM_SHARE_LOCK_EN
  localparam int BW = $clog2(MAX_BURST+1);

  logic [BW-1:0] burst_cnt;
  logic [BW-1:0] cnt_next;
  logic [IW-1:0] lock_g;
  logic          locked;

  assign locked   = (burst_cnt != '0) && req_valid[lock_g];
  assign cnt_next = locked ? burst_cnt + 1'b1 : BW'(1);
  // While a burst is open the search resumes just past the holder once it lets go.
  assign base     = (burst_cnt != '0) ? nxt(lock_g) : ptr;
`else
  assign base     = ptr;
`endif

  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(base) + k) % N);
      if (!grant_vld && req_valid[cand]) begin
        grant     = cand;
        grant_vld = 1'b1;
      end
    end
`ifdef STREAM_SHARE_LOCK_EN
    if (locked) begin
      grant     = lock_g;
      grant_vld = 1'b1;
    end
`endif
  end

  assign full  = (count == PW'(DEPTH));
  assign empty = (count == '0);
  assign head  = tag_mem[rd_ptr];

  // Full blocks issue even when a pop lands in the same cycle; reset masks issue.
  assign issue_ok   = nrst && !full;
  assign u_in       = req_data[int'(grant)*W +: W];
  assign u_in_valid = issue_ok && (|req_valid);
  assign push       = u_in_valid && u_in_ready;

  always_comb begin
    req_ready = '0;
    if (grant_vld && u_in_ready && issue_ok) req_ready[grant] = 1'b1;
  end

  assign u_out_ready = !empty && rsp_ready[head];
  assign pop         = u_out_valid && u_out_ready;
  assign rsp_data    = {N{u_out}};
  assign pending     = count;

  always_comb begin
    rsp_valid = '0;
    if (u_out_valid && !empty) rsp_valid[head] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= grant;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef STREAM_SHARE_LOCK_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ptr       <= '0;
      burst_cnt <= '0;
      lock_g    <= '0;
    end else if (push) begin
      if (int'(cnt_next) >= MAX_BURST) begin
        ptr       <= nxt(grant);
        burst_cnt <= '0;
      end else begin
        burst_cnt <= cnt_next;
        lock_g    <= grant;
      end
    end else if (burst_cnt != '0 && !req_valid[lock_g]) begin
      ptr       <= nxt(lock_g);
      burst_cnt <= '0;
    end
  end
`else
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ptr <= '0;
    end else if (push) begin
      ptr <= nxt(grant);
    end
  end
`endif

endmodule
